// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - timing defaults, state encoding and coordinate widths for the VGA frame probe
package vga_timing_pkg;

  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 521;
  localparam int HBP     = 144;
  localparam int HFP     = 784;
  localparam int VBP     = 31;
  localparam int VFP     = 511;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } probe_state_t;

  // A pixel counts as lit when any colour component is nonzero
  function automatic logic rgb_lit(input logic [4:0] r, input logic [5:0] g, input logic [4:0] b);
    return (|r) | (|g) | (|b);
  endfunction

endpackage

// File: rtl/vga_bbox_acc.sv
// rtl/vga_bbox_acc.sv - per-frame bounding box of lit pixels, published on frame end
module vga_bbox_acc
  import vga_timing_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic           frame_end,
  input  logic           pix_valid,
  input  logic           pix_lit,
  input  logic [X_W-1:0] pix_x,
  input  logic [Y_W-1:0] pix_y,
  output logic           frame_done,
  output logic           obj_found,
  output logic [X_W-1:0] bbox_x_min,
  output logic [X_W-1:0] bbox_x_max,
  output logic [Y_W-1:0] bbox_y_min,
  output logic [Y_W-1:0] bbox_y_max
);

  logic           any_q, any_d;
  logic [X_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [Y_W-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic           done_q, done_d, obj_q, obj_d;
  logic [X_W-1:0] bxmin_q, bxmin_d, bxmax_q, bxmax_d;
  logic [Y_W-1:0] bymin_q, bymin_d, bymax_q, bymax_d;

  logic           hit;
  logic           nx_any;
  logic [X_W-1:0] nx_xmin, nx_xmax;
  logic [Y_W-1:0] nx_ymin, nx_ymax;

  // Fold the current lit pixel into the running box, then publish or clear
  always_comb begin
    hit     = pix_valid && pix_lit;
    nx_any  = any_q | hit;
    nx_xmin = xmin_q;
    nx_xmax = xmax_q;
    nx_ymin = ymin_q;
    nx_ymax = ymax_q;
    if (hit) begin
      if (!any_q) begin
        nx_xmin = pix_x;
        nx_xmax = pix_x;
        nx_ymin = pix_y;
        nx_ymax = pix_y;
      end else begin
        if (pix_x < xmin_q) nx_xmin = pix_x;
        if (pix_x > xmax_q) nx_xmax = pix_x;
        if (pix_y < ymin_q) nx_ymin = pix_y;
        if (pix_y > ymax_q) nx_ymax = pix_y;
      end
    end

    any_d   = nx_any;
    xmin_d  = nx_xmin;
    xmax_d  = nx_xmax;
    ymin_d  = nx_ymin;
    ymax_d  = nx_ymax;
    done_d  = 1'b0;
    obj_d   = obj_q;
    bxmin_d = bxmin_q;
    bxmax_d = bxmax_q;
    bymin_d = bymin_q;
    bymax_d = bymax_q;

    if (!run) begin
      // Not locked: anything gathered so far belongs to an untrusted frame
      any_d  = 1'b0;
      xmin_d = '0;
      xmax_d = '0;
      ymin_d = '0;
      ymax_d = '0;
    end else if (frame_end) begin
      done_d = 1'b1;
      obj_d  = nx_any;
      if (nx_any) begin
        bxmin_d = nx_xmin;
        bxmax_d = nx_xmax;
        bymin_d = nx_ymin;
        bymax_d = nx_ymax;
      end
      any_d  = 1'b0;
      xmin_d = '0;
      xmax_d = '0;
      ymin_d = '0;
      ymax_d = '0;
    end
  end

  // Running box and published outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      any_q   <= 1'b0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      done_q  <= 1'b0;
      obj_q   <= 1'b0;
      bxmin_q <= '0;
      bxmax_q <= '0;
      bymin_q <= '0;
      bymax_q <= '0;
    end else begin
      any_q   <= any_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      done_q  <= done_d;
      obj_q   <= obj_d;
      bxmin_q <= bxmin_d;
      bxmax_q <= bxmax_d;
      bymin_q <= bymin_d;
      bymax_q <= bymax_d;
    end
  end

  assign frame_done = done_q;
  assign obj_found  = obj_q;
  assign bbox_x_min = bxmin_q;
  assign bbox_x_max = bxmax_q;
  assign bbox_y_min = bymin_q;
  assign bbox_y_max = bymax_q;

endmodule

// File: rtl/vga_frame_probe.sv
// rtl/vga_frame_probe.sv - VGA sync lock, pixel recovery and lit-pixel bbox; SYNC_ERR_CNT_EN adds err_cnt
module vga_frame_probe
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL = vga_timing_pkg::H_TOTAL,
  parameter int V_TOTAL = vga_timing_pkg::V_TOTAL,
  parameter int HBP     = vga_timing_pkg::HBP,
  parameter int HFP     = vga_timing_pkg::HFP,
  parameter int VBP     = vga_timing_pkg::VBP,
  parameter int VFP     = vga_timing_pkg::VFP
) (
  input  logic           pclk,
  input  logic           reset,
  input  logic           pix_en,
  input  logic           hsync,
  input  logic           vsync,
  input  logic [4:0]     red,
  input  logic [5:0]     green,
  input  logic [4:0]     blue,
  output logic           locked,
  output logic           pixel_valid,
  output logic [X_W-1:0] pixel_x,
  output logic [Y_W-1:0] pixel_y,
  output logic           pixel_lit,
  output logic           frame_done,
  output logic           obj_found,
  output logic [X_W-1:0] bbox_x_min,
  output logic [X_W-1:0] bbox_x_max,
  output logic [Y_W-1:0] bbox_y_min,
  output logic [Y_W-1:0] bbox_y_max
`ifdef SYNC_ERR_CNT_EN
  ,
  output logic [15:0]    err_cnt
`endif
);

  localparam int HC_W = $clog2(2 * H_TOTAL);
  localparam int VC_W = $clog2(2 * V_TOTAL);

  localparam logic [HC_W-1:0] H_LAST    = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] H_SAT     = HC_W'(2 * H_TOTAL - 1);
  localparam logic [HC_W-1:0] H_PRE_SAT = HC_W'(2 * H_TOTAL - 2);
  localparam logic [HC_W-1:0] H_BP_C    = HC_W'(HBP);
  localparam logic [HC_W-1:0] H_FP_C    = HC_W'(HFP);
  localparam logic [VC_W-1:0] V_LAST    = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] V_SAT     = '1;
  localparam logic [VC_W-1:0] V_BP_C    = VC_W'(VBP);
  localparam logic [VC_W-1:0] V_FP_C    = VC_W'(VFP);

  logic [HC_W-1:0] hcount_q, hcount_d;
  logic [VC_W-1:0] vcount_q, vcount_d;
  logic            hs_prev_q, hs_prev_d;
  logic            vs_prev_q, vs_prev_d;
  probe_state_t    state_q, state_d;
  logic            chk_err_q, chk_err_d;
  logic            pixel_valid_q, pixel_valid_d;
  logic [X_W-1:0]  pixel_x_q, pixel_x_d;
  logic [Y_W-1:0]  pixel_y_q, pixel_y_d;
  logic            pixel_lit_q, pixel_lit_d;

  logic            hs_fall, vs_fall;
  logic            line_err, frame_err, any_err;
  logic            frame_end;
  logic            active;
  logic [HC_W-1:0] hx;
  logic [VC_W-1:0] vy;

  // Sample syncs on pix_en, recover counters, run the lock FSM and form the pixel stream
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    state_d       = state_q;
    chk_err_d     = chk_err_q;
    pixel_valid_d = 1'b0;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    pixel_lit_d   = pixel_lit_q;
    line_err      = 1'b0;
    frame_err     = 1'b0;
    any_err       = 1'b0;
    frame_end     = 1'b0;
    active        = 1'b0;
    hs_fall       = pix_en && !hsync && hs_prev_q;
    vs_fall       = pix_en && !vsync && vs_prev_q;
    hx            = '0;
    vy            = '0;

    if (pix_en) begin
      hs_prev_d = hsync;
      vs_prev_d = vsync;

      if (hs_fall) begin
        hcount_d = '0;
        line_err = (hcount_q != H_LAST);
        if (vs_fall) vcount_d = '0;
        else if (vcount_q != V_SAT) vcount_d = vcount_q + 1'b1;
      end else if (hcount_q != H_SAT) begin
        hcount_d = hcount_q + 1'b1;
        // Sync loss is flagged once, on the sample that reaches saturation
        line_err = (hcount_q == H_PRE_SAT);
      end

      frame_err = vs_fall && (vcount_q != V_LAST);
      // Timing is only judged once a frame start has been seen
      any_err   = (state_q != HUNT) && (line_err || frame_err);

      case (state_q)
        HUNT: begin
          if (vs_fall) begin
            state_d   = CHECK;
            chk_err_d = 1'b0;
          end
        end
        CHECK: begin
          if (vs_fall) begin
            if (any_err || chk_err_q) chk_err_d = 1'b0;
            else                      state_d   = LOCKED;
          end else if (any_err) begin
            chk_err_d = 1'b1;
          end
        end
        LOCKED: begin
          if (any_err)      state_d   = HUNT;
          else if (vs_fall) frame_end = 1'b1;
        end
        default: state_d = HUNT;
      endcase

      active = (state_q == LOCKED) &&
               (hcount_d >= H_BP_C) && (hcount_d < H_FP_C) &&
               (vcount_d >= V_BP_C) && (vcount_d < V_FP_C);
      if (active) begin
        hx            = hcount_d - H_BP_C;
        vy            = vcount_d - V_BP_C;
        pixel_valid_d = 1'b1;
        pixel_x_d     = X_W'(hx);
        pixel_y_d     = Y_W'(vy);
        pixel_lit_d   = rgb_lit(red, green, blue);
      end
    end
  end

  // Timing state and registered pixel outputs
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      state_q       <= HUNT;
      chk_err_q     <= 1'b0;
      pixel_valid_q <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      pixel_lit_q   <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      state_q       <= state_d;
      chk_err_q     <= chk_err_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      pixel_lit_q   <= pixel_lit_d;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign pixel_valid = pixel_valid_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign pixel_lit   = pixel_lit_q;

  vga_bbox_acc u_bbox (
    .clk        (pclk),
    .rst        (reset),
    .run        (locked),
    .frame_end  (frame_end),
    .pix_valid  (pixel_valid_q),
    .pix_lit    (pixel_lit_q),
    .pix_x      (pixel_x_q),
    .pix_y      (pixel_y_q),
    .frame_done (frame_done),
    .obj_found  (obj_found),
    .bbox_x_min (bbox_x_min),
    .bbox_x_max (bbox_x_max),
    .bbox_y_min (bbox_y_min),
    .bbox_y_max (bbox_y_max)
  );

`ifdef SYNC_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating count of erroneous samples; coincident line and frame errors count once
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (any_err && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  // Error counter register, cleared only by reset
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_vga_frame_probe.sv
// tb/tb_vga_frame_probe.sv - directed self-checking bench for vga_frame_probe on a reduced 40x16 raster
module tb_vga_frame_probe;

  localparam int H   = 40;
  localparam int V   = 16;
  localparam int HBP = 8;
  localparam int HFP = 36;
  localparam int VBP = 3;
  localparam int VFP = 14;

  logic       pclk = 1'b0;
  logic       reset;
  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic [4:0] red;
  logic [5:0] green;
  logic [4:0] blue;
  logic       locked;
  logic       pixel_valid;
  logic [9:0] pixel_x;
  logic [8:0] pixel_y;
  logic       pixel_lit;
  logic       frame_done;
  logic       obj_found;
  logic [9:0] bbox_x_min;
  logic [9:0] bbox_x_max;
  logic [8:0] bbox_y_min;
  logic [8:0] bbox_y_max;
`ifdef SYNC_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  int n_total = 0;
  int n_bad   = 0;

  int fd_cnt  = 0;
  int pv_cnt  = 0;
  int lit_cnt = 0;
  int lit_x   = 0;
  int lit_y   = 0;

  bit          lit_en  = 1'b0;
  int          lx0     = 0;
  int          lx1     = 0;
  int          ly0     = 0;
  int          ly1     = 0;
  logic [15:0] lit_rgb = 16'h0000;

  int pv0;
  int lit0;

  vga_frame_probe #(
    .H_TOTAL(H), .V_TOTAL(V), .HBP(HBP), .HFP(HFP), .VBP(VBP), .VFP(VFP)
  ) dut (
    .pclk        (pclk),
    .reset       (reset),
    .pix_en      (pix_en),
    .hsync       (hsync),
    .vsync       (vsync),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .locked      (locked),
    .pixel_valid (pixel_valid),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_lit   (pixel_lit),
    .frame_done  (frame_done),
    .obj_found   (obj_found),
    .bbox_x_min  (bbox_x_min),
    .bbox_x_max  (bbox_x_max),
    .bbox_y_min  (bbox_y_min),
    .bbox_y_max  (bbox_y_max)
`ifdef SYNC_ERR_CNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  always #5 pclk = ~pclk;

  // Pulse monitor, sampled on the inactive edge
  always @(negedge pclk) begin
    if (!reset) begin
      if (frame_done) fd_cnt++;
      if (pixel_valid) begin
        pv_cnt++;
        if (pixel_lit) begin
          lit_cnt++;
          lit_x = int'(pixel_x);
          lit_y = int'(pixel_y);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // One pix_en sample spread over three pclks
  task automatic samp(input logic hs, input logic vs, input logic [15:0] rgb);
    @(negedge pclk);
    hsync  = hs;
    vsync  = vs;
    red    = rgb[15:11];
    green  = rgb[10:5];
    blue   = rgb[4:0];
    pix_en = 1'b1;
    @(negedge pclk);
    pix_en = 1'b0;
    @(negedge pclk);
  endtask

  task automatic drive(input int h, input int v, input bit hold_hs);
    logic hs;
    logic vs;
    bit   l;
    hs = hold_hs ? 1'b1 : (h >= 4);
    vs = (v >= 2);
    l  = lit_en && (h >= lx0) && (h <= lx1) && (v >= ly0) && (v <= ly1);
    samp(hs, vs, l ? lit_rgb : 16'h0000);
  endtask

  task automatic line(input int v, input int h0, input int n);
    for (int h = h0; h < n; h++) drive(h, v, 1'b0);
  endtask

  // Rest of a frame after its first (vsync-fall) sample
  task automatic body(input int nlines);
    line(0, 1, H);
    for (int v = 1; v < nlines; v++) line(v, 0, H);
  endtask

  task automatic frame_edge();
    drive(0, 0, 1'b0);
  endtask

  initial begin
    reset  = 1'b1;
    pix_en = 1'b0;
    hsync  = 1'b1;
    vsync  = 1'b1;
    red    = '0;
    green  = '0;
    blue   = '0;
    repeat (3) @(negedge pclk);
    reset = 1'b0;

    // Partial line, then asynchronous reset between clock edges
    for (int h = 10; h < 20; h++) drive(h, 5, 1'b0);
    #3 reset = 1'b1;
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_pixel_valid", pixel_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_obj_found", obj_found, 0);
    chk("rst_bbox_x_max", bbox_x_max, 0);
    @(negedge pclk);
    reset = 1'b0;

    // Ideal timing, black frames: lock after second vsync fall
    frame_edge();
    chk("hunt_to_check_unlocked", locked, 0);
    body(V);
    chk("check_before_2nd_fall", locked, 0);
    frame_edge();
    chk("locked_after_2nd_fall", locked, 1);
    chk("no_done_at_lock", fd_cnt, 0);
    body(V);
    frame_edge();
    chk("black_done", fd_cnt, 1);
    chk("black_obj", obj_found, 0);
    chk("black_bbox_x_max", bbox_x_max, 0);

    // Single lit sample at hcount 20, vcount 7
    lit_en = 1'b1; lx0 = 20; lx1 = 20; ly0 = 7; ly1 = 7; lit_rgb = 16'h0001;
    pv0 = pv_cnt; lit0 = lit_cnt;
    body(V);
    chk("pv_per_frame", pv_cnt - pv0, 308);
    chk("single_lit_cnt", lit_cnt - lit0, 1);
    chk("single_px", lit_x, 12);
    chk("single_py", lit_y, 4);
    frame_edge();
    chk("single_done", fd_cnt, 2);
    chk("single_obj", obj_found, 1);
    chk("single_xmin", bbox_x_min, 12);
    chk("single_xmax", bbox_x_max, 12);
    chk("single_ymin", bbox_y_min, 4);
    chk("single_ymax", bbox_y_max, 4);

    // Lit rectangle, hcount 13..17, vcount 5..9
    lx0 = 13; lx1 = 17; ly0 = 5; ly1 = 9; lit_rgb = 16'h07E0;
    lit0 = lit_cnt;
    body(V);
    chk("rect_lit_cnt", lit_cnt - lit0, 25);
    frame_edge();
    chk("rect_done", fd_cnt, 3);
    chk("rect_obj", obj_found, 1);
    chk("rect_xmin", bbox_x_min, 5);
    chk("rect_xmax", bbox_x_max, 9);
    chk("rect_ymin", bbox_y_min, 2);
    chk("rect_ymax", bbox_y_max, 6);

    // Empty frame keeps previous box
    lit_en = 1'b0;
    body(V);
    frame_edge();
    chk("empty_done", fd_cnt, 4);
    chk("empty_obj", obj_found, 0);
    chk("empty_hold_xmin", bbox_x_min, 5);
    chk("empty_hold_ymax", bbox_y_max, 6);

    // Short line (39 samples) with a lit pixel earlier in the frame
    lit_en = 1'b1; lx0 = 20; lx1 = 20; ly0 = 7; ly1 = 7; lit_rgb = 16'hF800;
    line(0, 1, H);
    for (int v = 1; v < 10; v++) line(v, 0, H);
    line(10, 0, H - 1);
    chk("short_still_locked", locked, 1);
    drive(0, 11, 1'b0);
    chk("short_unlock", locked, 0);
    line(11, 1, H);
    for (int v = 12; v < V; v++) line(v, 0, H);
    lit_en = 1'b0;
    frame_edge();
    chk("short_hunt_to_check", locked, 0);
    chk("short_no_done", fd_cnt, 4);
    body(V);
    frame_edge();
    chk("short_relock", locked, 1);
    chk("short_relock_no_done", fd_cnt, 4);
`ifdef SYNC_ERR_CNT_EN
    chk("err_cnt_short", err_cnt, 1);
`endif
    body(V);
    frame_edge();
    chk("after_relock_done", fd_cnt, 5);
    chk("discard_obj", obj_found, 0);
    chk("discard_hold_xmin", bbox_x_min, 5);

    // hsync held high until hcount saturates at 2*H-1
    line(0, 1, H);
    line(1, 0, H);
    drive(0, 2, 1'b0);
    for (int h = 1; h < 2 * H - 1; h++) drive(h, 2, 1'b1);
    chk("sat_pre_locked", locked, 1);
    drive(2 * H - 1, 2, 1'b1);
    chk("sat_unlock", locked, 0);
    for (int v = 3; v < V; v++) line(v, 0, H);
    frame_edge();
    chk("sat_check_unlocked", locked, 0);
    chk("sat_no_done", fd_cnt, 5);
    body(V);
    frame_edge();
    chk("sat_relock", locked, 1);
`ifdef SYNC_ERR_CNT_EN
    chk("err_cnt_sat", err_cnt, 2);
`endif

    // Frame of V-1 lines: frame error wins over frame_done
    body(V - 1);
    frame_edge();
    chk("short_frame_unlock", locked, 0);
    chk("short_frame_no_done", fd_cnt, 5);
`ifdef SYNC_ERR_CNT_EN
    chk("err_cnt_frame", err_cnt, 3);
`endif
    body(V);
    frame_edge();
    chk("frame_err_in_check", locked, 0);
    body(V);
    frame_edge();
    chk("frame_err_relock", locked, 1);

    // Lit frame after recovery, then reset mid-frame
    lit_en = 1'b1; lx0 = 13; lx1 = 17; ly0 = 5; ly1 = 9; lit_rgb = 16'h07E0;
    body(V);
    frame_edge();
    chk("final_done", fd_cnt, 6);
    chk("final_obj", obj_found, 1);
    chk("final_xmax", bbox_x_max, 9);
    line(0, 1, H);
    line(1, 0, H);
    for (int h = 0; h < 10; h++) drive(h, 2, 1'b0);
    #3 reset = 1'b1;
    #1;
    chk("midrst_locked", locked, 0);
    chk("midrst_obj", obj_found, 0);
    chk("midrst_xmax", bbox_x_max, 0);
    chk("midrst_ymax", bbox_y_max, 0);
    @(negedge pclk);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
